iddr: RTL and testbench

IDDR -- requirements
Module: iddr

---
 rtl/iddr_pkg.sv | 35 +++
 rtl/iddr_capture.sv | 64 ++++++
 rtl/iddr.sv | 156 +++++++++++++++
 tb/tb_iddr.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/iddr_pkg.sv
// -----------------------------------------------------------------------------
// iddr_pkg -- shared types and constants for the IDDR deserializer.
//
// Contents:
//   state_e     : sequencer states (IDLE, WAIT, RUN)
//   WORD_W      : width of the deserialized word (4 bits)
//   CNT_W       : width of the start-up delay counter (8 bits, READY_DELAY <= 255)
//   word_out()  : output polarity applied to the assembled window
//
// Build option:
//   IDDR_DATA_INVERT_EN defined   -> q_o carries the bitwise inverse of the window
//   IDDR_DATA_INVERT_EN undefined -> q_o carries the window unchanged
//   Only the data polarity changes; timing is identical in both builds.
// -----------------------------------------------------------------------------
package iddr_pkg;

  localparam int WORD_W = 4;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RUN  = 2'd2
  } state_e;

  // Polarity applied to the window before it lands in q_o.
  function automatic logic [WORD_W-1:0] word_out(input logic [WORD_W-1:0] window);
`ifdef IDDR_DATA_INVERT_EN
    return ~window;
`else
    return window;
`endif
  endfunction

endpackage

// File: rtl/iddr_capture.sv
// -----------------------------------------------------------------------------
// iddr_capture -- dual-edge sampler and 4-bit shift window.
//
// datain_i is sampled on every clk_i edge:
//   r_q : R(n), the bit present at rising edge n
//   f_q : F(n), the bit present at the falling edge after rising edge n
// At rising edge n+1 the pair {F(n), R(n)} is shifted into the top of the
// window and the previous pair moves to the bottom, so between rising edges
// n+1 and n+2 the window holds {F(n), R(n), F(n-1), R(n-1)} as bits [3:0].
// This block runs continuously; its consumer decides when to load the window.
//
// Ports:
//   clk_i     in  1       clock; datain_i sampled on both edges
//   rst_i     in  1       asynchronous active-high reset
//   datain_i  in  1       serial DDR data
//   window_o  out WORD_W  current window, bit 0 oldest, bit 3 newest
// -----------------------------------------------------------------------------
module iddr_capture
  import iddr_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              datain_i,
  output logic [WORD_W-1:0] window_o
);

  logic              r_d, r_q;
  logic              f_d, f_q;
  logic [WORD_W-1:0] win_d, win_q;

  // NOTE: every signal assigned in always_comb gets a value on every path
  // (here trivially), so no latch is inferred.
  always_comb begin
    r_d   = datain_i;
    f_d   = datain_i;
    // Newest pair enters at the top; F sits above R because it was sampled later.
    win_d = {f_q, r_q, win_q[WORD_W-1:2]};
  end

  // NOTE: clocked state uses non-blocking assignments only, so every flop
  // sees the pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_q   <= 1'b0;
      win_q <= '0;
    end else begin
      r_q   <= r_d;
      win_q <= win_d;
    end
  end

  // Falling-edge half of the DDR capture; re-timed into the rising-edge
  // domain by the window register above.
  always_ff @(negedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      f_q <= 1'b0;
    end else begin
      f_q <= f_d;
    end
  end

  assign window_o = win_q;

endmodule

// File: rtl/iddr.sv
// -----------------------------------------------------------------------------
// iddr -- 1:4 DDR deserializer with start-up sequencer and word-alignment slip.
//
// After start_i is sampled high the block waits READY_DELAY+1 rising edges
// (IDLE -> WAIT, counting, WAIT -> RUN), then raises ready_o. In RUN a 1-bit
// phase toggles each cycle; on every rising edge where phase is 1 the capture
// window is loaded into q_o and sclk_en_o pulses for one cycle, giving one
// word every two cycles. A rising edge on alignwd_i in RUN freezes the phase
// for one cycle, delaying the word boundary by two bits (one strobe gap of 3).
// Dropping start_i returns to IDLE from any state, discarding a pending slip.
//
// Parameters:
//   READY_DELAY  start-up delay count, legal range 1..255 (default 16)
//
// Ports:
//   clk_i      in  1       clock (datain_i on both edges, rest rising-edge)
//   rst_i      in  1       asynchronous active-high reset
//   datain_i   in  1       serial DDR data
//   start_i    in  1       level enable for start-up / run
//   alignwd_i  in  1       word-alignment slip request (rising-edge sensitive)
//   q_o        out WORD_W  deserialized word, q_o[0] oldest, q_o[3] newest
//   sclk_en_o  out 1       one-cycle strobe on each q_o update
//   ready_o    out 1       high while in RUN
//
// Build option: IDDR_DATA_INVERT_EN inverts q_o (see iddr_pkg::word_out).
// -----------------------------------------------------------------------------
module iddr
  import iddr_pkg::*;
#(
  parameter int unsigned READY_DELAY = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              datain_i,
  input  logic              start_i,
  input  logic              alignwd_i,
  output logic [WORD_W-1:0] q_o,
  output logic              sclk_en_o,
  output logic              ready_o
);

  localparam logic [CNT_W-1:0] DELAY_CNT = CNT_W'(READY_DELAY);

  logic [WORD_W-1:0] window;

  state_e            state_d, state_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic              phase_d, phase_q;
  logic              slip_d, slip_q;
  logic              align_d, align_q;
  logic [WORD_W-1:0] q_d, q_q;
  logic              sclk_en_d, sclk_en_q;
  logic              ready_d, ready_q;
  logic              align_rise;

  iddr_capture u_capture (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .datain_i (datain_i),
    .window_o (window)
  );

  // alignwd_i is registered once; a rise is "high now, low last cycle".
  assign align_rise = alignwd_i & ~align_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    phase_d   = phase_q;
    slip_d    = slip_q;
    align_d   = alignwd_i;
    q_d       = q_q;
    sclk_en_d = 1'b0;
    ready_d   = 1'b0;

    if (!start_i) begin
      // Dropping start wins over everything, including a slip arriving now.
      state_d = IDLE;
      cnt_d   = '0;
      phase_d = 1'b0;
      slip_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = WAIT;
          cnt_d   = '0;
          phase_d = 1'b0;
        end

        WAIT: begin
          phase_d = 1'b0;
          if (cnt_q == DELAY_CNT) begin
            state_d = RUN;
            ready_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        RUN: begin
          ready_d = 1'b1;
          if (slip_q) begin
            // Freeze cycle: phase holds and no word is produced, which
            // stretches this strobe interval from 2 to 3 cycles.
            slip_d = 1'b0;
          end else begin
            phase_d = ~phase_q;
            if (phase_q) begin
              q_d       = word_out(window);
              sclk_en_d = 1'b1;
            end
            // Edges arriving during the freeze cycle fall into the branch
            // above and are ignored.
            if (align_rise) begin
              slip_d = 1'b1;
            end
          end
        end

        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          phase_d = 1'b0;
          slip_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      phase_q   <= 1'b0;
      slip_q    <= 1'b0;
      align_q   <= 1'b0;
      q_q       <= '0;
      sclk_en_q <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      slip_q    <= slip_d;
      align_q   <= align_d;
      q_q       <= q_d;
      sclk_en_q <= sclk_en_d;
      ready_q   <= ready_d;
    end
  end

  assign q_o       = q_q;
  assign sclk_en_o = sclk_en_q;
  assign ready_o   = ready_q;

endmodule

// File: tb/tb_iddr.sv
// -----------------------------------------------------------------------------
// tb_iddr -- scoreboard bench for iddr (READY_DELAY = 16).
//
// Stimulus pushes the expected (cycle, word) of every strobe into a queue;
// a monitor sampling on the falling edge pops one entry per sclk_en_o pulse.
// cyc is the index of the most recent rising edge. Start is raised so that
// its sampling edge E is even; strobes then fall on E+19, E+21, ... .
// Data modes: ALT drives R=1/F=0; P0011 drives R(n)=F(n)=n[0], so a window
// loaded at an odd edge reads 4'b1100 and at an even edge 4'b0011.
// -----------------------------------------------------------------------------
module tb_iddr;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       datain_i;
  logic       start_i;
  logic       alignwd_i;
  logic [3:0] q_o;
  logic       sclk_en_o;
  logic       ready_o;

  iddr #(.READY_DELAY(16)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .datain_i  (datain_i),
    .start_i   (start_i),
    .alignwd_i (alignwd_i),
    .q_o       (q_o),
    .sclk_en_o (sclk_en_o),
    .ready_o   (ready_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [3:0] exp_word(input logic [3:0] w);
`ifdef IDDR_DATA_INVERT_EN
    return ~w;
`else
    return w;
`endif
  endfunction

  // ---------------- data driver ----------------
  typedef enum {D_ZERO, D_ALT, D_P0011} dmode_e;
  dmode_e dmode = D_ZERO;

  function automatic logic rise_bit(input int n);
    case (dmode)
      D_ALT:   return 1'b1;
      D_P0011: return n[0];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic fall_bit(input int n);
    case (dmode)
      D_ALT:   return 1'b0;
      D_P0011: return n[0];
      default: return 1'b0;
    endcase
  endfunction

  initial begin
    datain_i = 1'b0;
    forever begin
      @(negedge clk_i); #1;
      datain_i = rise_bit(cyc + 1);  // sampled at the next rising edge
      @(posedge clk_i); #1;
      datain_i = fall_bit(cyc);      // sampled at the following falling edge
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    int         cyc;
    logic [3:0] q;
  } exp_t;
  exp_t sb[$];

  task automatic expect_strobe(input int c, input logic [3:0] w);
    exp_t e;
    e.cyc = c;
    e.q   = exp_word(w);
    sb.push_back(e);
  endtask

  initial begin
    forever begin
      @(negedge clk_i);
      if (sclk_en_o === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_strobe", 32'(sclk_en_o), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("strobe_cycle", cyc, e.cyc);
          check("strobe_q", 32'(q_o), 32'(e.q));
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_to(input int n);
    while (cyc < n) begin
      @(posedge clk_i); #1;
    end
  endtask

  task automatic start_even(output int e);
    @(posedge clk_i); #1;
    if (((cyc + 1) % 2) != 0) begin
      @(posedge clk_i); #1;
    end
    start_i = 1'b1;
    e = cyc + 1;
  endtask

  task automatic check_ready_rise(input int e);
    wait_to(e + 16);
    check("ready_low_before_delay", 32'(ready_o), 32'd0);
    wait_to(e + 17);
    check("ready_rise", 32'(ready_o), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int e;
    int r;
    rst_i     = 1'b1;
    start_i   = 1'b0;
    alignwd_i = 1'b0;
    dmode     = D_ALT;

    #2;
    check("reset_q", 32'(q_o), 32'd0);
    check("reset_sclk_en", 32'(sclk_en_o), 32'd0);
    check("reset_ready", 32'(ready_o), 32'd0);
    #22 rst_i = 1'b0;
    wait_to(cyc + 3);
    check("idle_ready", 32'(ready_o), 32'd0);
    check("idle_q", 32'(q_o), 32'd0);

    // Test 1: start-up timing, alternating data, start drop in RUN.
    start_even(e);
    for (int k = 0; k < 6; k++) expect_strobe(e + 19 + 2 * k, 4'b0101);
    check_ready_rise(e);
    wait_to(e + 30);
    check("ready_in_run", 32'(ready_o), 32'd1);
    start_i = 1'b0;
    wait_to(e + 31);
    check("stop_ready", 32'(ready_o), 32'd0);
    check("stop_sclk_en", 32'(sclk_en_o), 32'd0);
    check("stop_q_frozen", 32'(q_o), 32'(exp_word(4'b0101)));

    // Test 2: single slip pulse, then start drop coinciding with an align edge.
    dmode = D_P0011;
    wait_to(cyc + 4);
    start_even(e);
    expect_strobe(e + 19, 4'b1100);
    expect_strobe(e + 21, 4'b1100);
    check_ready_rise(e);
    wait_to(e + 21);
    alignwd_i = 1'b1;
    wait_to(e + 22);
    alignwd_i = 1'b0;
    for (int k = 0; k < 4; k++) expect_strobe(e + 24 + 2 * k, 4'b0011);
    wait_to(e + 31);
    start_i   = 1'b0;
    alignwd_i = 1'b1;
    wait_to(e + 32);
    check("slip_stop_ready", 32'(ready_o), 32'd0);
    check("slip_stop_sclk_en", 32'(sclk_en_o), 32'd0);
    alignwd_i = 1'b0;
    wait_to(e + 34);
    check("slip_stop_q_frozen", 32'(q_o), 32'(exp_word(4'b0011)));

    // Test 3: align edge in WAIT ignored, align held 20 cycles -> one slip.
    // A slip left over from test 2 would shift the first strobes here.
    wait_to(cyc + 2);
    start_even(e);
    expect_strobe(e + 19, 4'b1100);
    expect_strobe(e + 21, 4'b1100);
    wait_to(e + 4);
    alignwd_i = 1'b1;
    wait_to(e + 5);
    alignwd_i = 1'b0;
    check_ready_rise(e);
    wait_to(e + 21);
    alignwd_i = 1'b1;
    for (int k = 0; k < 11; k++) expect_strobe(e + 24 + 2 * k, 4'b0011);
    wait_to(e + 41);
    alignwd_i = 1'b0;
    wait_to(e + 45);
    start_i = 1'b0;
    wait_to(e + 46);
    check("hold_stop_ready", 32'(ready_o), 32'd0);

    // Test 4: asynchronous reset mid-RUN, then full restart.
    dmode = D_ALT;
    wait_to(cyc + 4);
    start_even(e);
    expect_strobe(e + 19, 4'b0101);
    expect_strobe(e + 21, 4'b0101);
    check_ready_rise(e);
    wait_to(e + 23);
    check("pre_reset_sclk_en", 32'(sclk_en_o), 32'd1);
    check("pre_reset_q", 32'(q_o), 32'(exp_word(4'b0101)));
    #2 rst_i = 1'b1;
    #1;
    check("async_reset_q", 32'(q_o), 32'd0);
    check("async_reset_sclk_en", 32'(sclk_en_o), 32'd0);
    check("async_reset_ready", 32'(ready_o), 32'd0);
    #2 rst_i = 1'b0;
    r = cyc + 1;
    expect_strobe(r + 19, 4'b0101);
    expect_strobe(r + 21, 4'b0101);
    check_ready_rise(r);
    wait_to(r + 22);
    start_i = 1'b0;
    wait_to(r + 23);
    check("final_stop_ready", 32'(ready_o), 32'd0);
    check("final_stop_sclk_en", 32'(sclk_en_o), 32'd0);
    check("final_stop_q", 32'(q_o), 32'(exp_word(4'b0101)));

    wait_to(cyc + 5);
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
